// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared unsigned MAC stepped across TAPS coefficients per sample,
// with a circular sample delay line, runtime coefficient writes and valid/ready handshakes.
module fir_mac_sequencer #(
  parameter int DATA_W = 3,
  parameter int COEF_W = 3,
  parameter int TAPS   = 3,
  parameter int ACC_W  = 9,
  localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic [DATA_W-1:0] i_x,
  input  logic              i_x_valid,
  output logic              o_x_ready,
  output logic [ACC_W-1:0]  o_y,
  output logic              o_y_valid,
  input  logic              i_y_ready,
  input  logic              i_coef_we,
  input  logic [AW-1:0]     i_coef_addr,
  input  logic [COEF_W-1:0] i_coef_data,
  output logic              o_coef_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);

  state_t            r_state;
  logic [DATA_W-1:0] r_delay [TAPS];
  logic [COEF_W-1:0] r_coef  [TAPS];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_newest_ptr;
  logic [AW-1:0]     r_idx;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_y;
  logic              r_y_valid;
  logic              r_coef_err;

  logic              w_accept;
  logic              w_coef_ok;
  logic [AW-1:0]     w_rd_ptr;
  logic [ACC_W-1:0]  w_prod;
  logic [ACC_W-1:0]  w_sum;

  // (newest - off) mod TAPS without a divider; one wrap correction is enough since off < TAPS.
  function automatic logic [AW-1:0] tap_ptr(input logic [AW-1:0] newest,
                                            input logic [AW-1:0] off);
    logic [AW:0] diff;
    diff = {1'b0, newest} - {1'b0, off};
    if (newest < off) diff = diff + TAPS_W;
    return diff[AW-1:0];
  endfunction

  assign w_accept  = (r_state == S_IDLE) && i_x_valid;
  assign w_coef_ok = (r_state == S_IDLE) && ({1'b0, i_coef_addr} < TAPS_W);
  assign w_rd_ptr  = tap_ptr(r_newest_ptr, r_idx);
  assign w_prod    = ACC_W'(r_coef[r_idx]) * ACC_W'(r_delay[w_rd_ptr]);
  assign w_sum     = r_acc + w_prod;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < TAPS; i++) begin
        r_delay[i] <= '0;
        r_coef[i]  <= '0;
      end
      r_wr_ptr     <= '0;
      r_newest_ptr <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_y          <= '0;
      r_y_valid    <= 1'b0;
      r_coef_err   <= 1'b0;
    end else begin
      r_coef_err <= i_coef_we && !w_coef_ok;
      if (i_coef_we && w_coef_ok) r_coef[i_coef_addr] <= i_coef_data;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_delay[r_wr_ptr] <= i_x;
            r_newest_ptr      <= r_wr_ptr;
            r_wr_ptr          <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            r_acc             <= '0;
            r_idx             <= '0;
            r_state           <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_idx == LAST) begin
            r_y       <= w_sum;
            r_y_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          // o_y deliberately keeps its value after the handshake.
          if (i_y_ready) begin
            r_y_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x_ready  = (r_state == S_IDLE);
  assign o_busy     = (r_state != S_IDLE);
  assign o_y        = r_y;
  assign o_y_valid  = r_y_valid;
  assign o_coef_err = r_coef_err;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomized bench for fir_mac_sequencer against a convolution-sum reference model.
module tb_fir_mac_sequencer;

  localparam int DATA_W = 3;
  localparam int COEF_W = 3;
  localparam int TAPS   = 3;
  localparam int ACC_W  = 9;
  localparam int AW     = 2;

  logic              i_CLK = 1'b0;
  logic              i_RST = 1'b0;
  logic [DATA_W-1:0] i_x = '0;
  logic              i_x_valid = 1'b0;
  logic              o_x_ready;
  logic [ACC_W-1:0]  o_y;
  logic              o_y_valid;
  logic              i_y_ready = 1'b1;
  logic              i_coef_we = 1'b0;
  logic [AW-1:0]     i_coef_addr = '0;
  logic [COEF_W-1:0] i_coef_data = '0;
  logic              o_coef_err;
  logic              o_busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: coefficient table and full history of accepted samples.
  int m_coef [TAPS];
  int hist [$];

  fir_mac_sequencer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_x(i_x), .i_x_valid(i_x_valid), .o_x_ready(o_x_ready),
    .o_y(o_y), .o_y_valid(o_y_valid), .i_y_ready(i_y_ready), .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data), .o_coef_err(o_coef_err),
    .o_busy(o_busy)
  );

  always #5 i_CLK = ~i_CLK;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, observed running, expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y();
    int s = 0;
    for (int i = 0; i < TAPS; i++)
      if (hist.size() > i) s += m_coef[i] * hist[hist.size() - 1 - i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
    hist.delete();
  endtask

  task automatic write_coef(input int addr, input int data);
    i_coef_we   = 1'b1;
    i_coef_addr = AW'(addr);
    i_coef_data = COEF_W'(data);
    tick();
    i_coef_we = 1'b0;
    if (addr < TAPS) m_coef[addr] = data;
    check("coef_err_idle", o_coef_err, (addr >= TAPS) ? 1 : 0);
    tick();
    check("coef_err_drop", o_coef_err, 0);
  endtask

  // One sample through the engine. bad_wr: write attempt during MAC; sim_wr: coef[0] write on
  // the accept edge; hold: cycles of i_y_ready=0 while in DONE, with stray sample offers.
  task automatic run_sample(input int x, input bit bad_wr, input bit sim_wr, input int sim_data,
                            input int hold);
    int cyc;
    int exp_y;
    logic [ACC_W-1:0] y_seen;
    i_y_ready = (hold == 0);
    i_x       = DATA_W'(x);
    i_x_valid = 1'b1;
    if (sim_wr) begin
      i_coef_we = 1'b1; i_coef_addr = '0; i_coef_data = COEF_W'(sim_data);
      m_coef[0] = sim_data;
    end
    check("x_ready_idle", o_x_ready, 1);
    tick();
    i_x_valid = 1'b0;
    hist.push_back(x);
    exp_y = model_y();
    if (sim_wr) begin
      i_coef_we = 1'b0;
      check("coef_err_sim", o_coef_err, 0);
    end
    check("busy_mac", o_busy, 1);
    if (bad_wr) begin
      i_coef_we = 1'b1; i_coef_addr = '0; i_coef_data = 3'd7;
    end
    cyc = 0;
    while (!o_y_valid && cyc < 12) begin
      tick();
      cyc++;
      if (bad_wr && cyc == 1) begin
        i_coef_we = 1'b0;
        check("coef_err_mac", o_coef_err, 1);
      end
      if (bad_wr && cyc == 2) check("coef_err_mac_drop", o_coef_err, 0);
    end
    check("latency", cyc, TAPS);
    check("y", o_y, exp_y);
    y_seen = o_y;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        i_x = 3'd5; i_x_valid = 1'b1;
        tick();
        check("bp_valid", o_y_valid, 1);
        check("bp_y_stable", o_y, y_seen);
        check("bp_x_ready", o_x_ready, 0);
      end
      i_x_valid = 1'b0;
      i_y_ready = 1'b1;
    end
    tick();
    check("x_ready_after", o_x_ready, 1);
    check("valid_drop", o_y_valid, 0);
    check("y_kept", o_y, y_seen);
  endtask

  initial begin
    model_reset();
    i_RST = 1'b1;
    tick();
    check("rst_y", o_y, 0);
    check("rst_valid", o_y_valid, 0);
    check("rst_err", o_coef_err, 0);
    check("rst_busy", o_busy, 0);
    i_RST = 1'b0;
    tick();
    check("rst_x_ready", o_x_ready, 1);

    // Impulse response 4,1,2,0
    write_coef(0, 4); write_coef(1, 1); write_coef(2, 2);
    run_sample(1, 0, 0, 0, 0); check("imp0", o_y, 4);
    run_sample(0, 0, 0, 0, 0); check("imp1", o_y, 1);
    run_sample(0, 0, 0, 0, 0); check("imp2", o_y, 2);
    run_sample(0, 0, 0, 0, 0); check("imp3", o_y, 0);

    // Protected coefficients: MAC-time write and out-of-range address rejected
    run_sample(1, 1, 0, 0, 0); check("prot0", o_y, 4);
    run_sample(0, 0, 0, 0, 0); check("prot1", o_y, 1);
    run_sample(0, 0, 0, 0, 0); check("prot2", o_y, 2);
    write_coef(3, 6);

    // Backpressure with stray sample offers
    run_sample(3, 0, 0, 0, 5); check("bp_y", o_y, 12);
    run_sample(0, 0, 0, 0, 0); check("bp_next", o_y, 3);

    // Full scale
    write_coef(0, 7); write_coef(1, 7); write_coef(2, 7);
    run_sample(0, 0, 0, 0, 0);
    run_sample(7, 0, 0, 0, 0); check("fs0", o_y, 49);
    run_sample(7, 0, 0, 0, 0); check("fs1", o_y, 98);
    run_sample(7, 0, 0, 0, 0); check("fs2", o_y, 147);

    // Reset on the second MAC cycle
    i_x = 3'd6; i_x_valid = 1'b1;
    tick();
    i_x_valid = 1'b0;
    tick();
    check("mid_busy", o_busy, 1);
    i_RST = 1'b1;
    #1;
    check("mid_rst_y", o_y, 0);
    check("mid_rst_valid", o_y_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_err", o_coef_err, 0);
    tick();
    i_RST = 1'b0;
    model_reset();
    tick();
    run_sample(1, 0, 0, 0, 0); check("post_rst_y", o_y, 0);

    // Coefficient write on the accept edge
    run_sample(1, 0, 1, 5, 0); check("sim_y", o_y, 5);

    // Randomized traffic
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) write_coef($urandom_range(0, 3), $urandom_range(0, 7));
      run_sample($urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller. It replaces the unrolled tap chain with one shared multiply-accumulate unit stepped across all taps. It owns the sample delay line (circular buffer) and the coefficient register file, and accepts samples and returns results over valid/ready handshakes. It sits between the sample source and the downstream consumer, and is configured at runtime through a coefficient write port.

Parameters:
DATA_W, 3, sample width (unsigned)
COEF_W, 3, coefficient width (unsigned)
TAPS, 3, number of taps (>=2)
ACC_W, 9, accumulator/output width; must be >= DATA_W+COEF_W+clog2(TAPS)

Ports:
i_CLK  in  1  clock, rising edge
i_RST  in  1  asynchronous reset, active-high
i_x  in  DATA_W  input sample
i_x_valid  in  1  sample valid
o_x_ready  out  1  sample accepted when i_x_valid & o_x_ready at rising edge
o_y  out  ACC_W  filter result
o_y_valid  out  1  result valid
i_y_ready  in  1  consumer ready
i_coef_we  in  1  coefficient write strobe
i_coef_addr  in  clog2(TAPS)  coefficient index
i_coef_data  in  COEF_W  coefficient value
o_coef_err  out  1  one-cycle pulse: write rejected
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_RST=1):
  - state=IDLE; delay line, coefficients, wr_ptr, newest_ptr, idx and acc all 0.
  - o_y=0, o_y_valid=0, o_coef_err=0, o_busy=0.
  - o_x_ready=1 as soon as reset deasserts (combinational: state==IDLE).
- States: IDLE, MAC, DONE.
- IDLE, on accept:
  - delay[wr_ptr]<=i_x; newest_ptr<=wr_ptr; wr_ptr<=(wr_ptr+1) mod TAPS.
  - acc<=0; idx<=0; go to MAC.
- MAC, one tap per cycle:
  - product = coef[idx]*delay[(newest_ptr-idx) mod TAPS]; acc<=acc+product.
  - When idx==TAPS-1: o_y<=acc+product, o_y_valid<=1, go to DONE. Otherwise idx<=idx+1.
- DONE:
  - o_y and o_y_valid are held stable while i_y_ready=0.
  - On i_y_ready=1: o_y_valid<=0 and go to IDLE. o_y keeps its last value.
- Latency: sample accepted at edge k gives o_y_valid=1 after edge k+TAPS.
- Throughput: with i_y_ready tied high, one sample per TAPS+2 cycles.
- Arithmetic is unsigned with zero extension to ACC_W. There is no saturation; ACC_W sizing guarantees no overflow.
- Result: y[n] = sum over i of coef[i]*x[n-i]. Delay entries not yet written read as 0.
- Coefficient writes:
  - Performed only when state==IDLE and i_coef_addr<TAPS.
  - A write in the same edge as a sample accept completes, and the run started by that accept uses the new value.
  - A write in MAC/DONE, or with addr>=TAPS, is ignored and pulses o_coef_err for exactly one cycle.
- i_x_valid outside IDLE has no effect; the sample is not captured.
- Reset mid-MAC or mid-DONE: the run is aborted, the result is lost, and coefficients and delay line are cleared.

Test Plan:
- Impulse: write coef {4,1,2}, then send samples 1,0,0,0 -> o_y = 4,1,2,0 in order; each o_y_valid asserts exactly 3 cycles after its accept edge.
- Full scale: all coefs 7, samples 7,7,7 -> o_y = 49, 98, 147. There is no wrap at 9 bits.
- Backpressure: hold i_y_ready=0 for 5 cycles in DONE -> o_y is stable, o_y_valid=1, o_x_ready=0, and i_x_valid pulses are not captured. Then raise i_y_ready -> o_x_ready=1 on the next cycle.
- Coef protection: during MAC, write addr 0 with 7 -> o_coef_err pulses 1 cycle and the next impulse result is unchanged (4,1,2). A write to addr 3 in IDLE -> o_coef_err pulses.
- Simultaneous events: in IDLE, on the same edge, write coef[0]=5 and accept sample 1 -> o_y=5.
- Reset mid-run: assert i_RST on the second MAC cycle -> all outputs 0 immediately. After release, an impulse with unwritten coefs gives o_y=0.
